data_memory_unit: RTL

Parametrised, byte-addressable data memory for the processor's load/store path. It replaces the fixed-size `DataMemory` and adds the following:
- configurable depth, base address and read latency;
- size and sign handling for byte, half-word and word loads;
- alignment and range checking, with sticky fault capture.

It sits between the execute stage's load/store unit and the memory-mapped data region that starts at `0x0010_0000`.

---
 rtl/data_memory_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/data_memory_unit.sv
// data_memory_unit
// Byte-addressable data memory for the load/store path.
//   ADDR_BASE    : byte address of word 0 (4-byte aligned)
//   DEPTH_WORDS  : number of 32-bit words (power of two, at least 2)
//   READ_LATENCY : cycles from an accepted load to read_valid (1..4)
// Ports:
//   clk, reset_n          : rising-edge clock, synchronous active-low reset
//   read_enable           : load request
//   write_enable          : store request
//   memory_addr           : byte address
//   data_type             : [1:0] size (byte/half/word/reserved), [2] unsigned load
//   write_data            : right-aligned store data
//   read_data, read_valid : extended load result and its one-cycle strobe
//   access_fault          : one-cycle pulse the cycle after a faulting request
//   fault_sticky          : set on the first fault, held until fault_clear
//   fault_addr            : address of the first fault since the last clear
//   fault_clear           : clears fault_sticky / fault_addr
// access_fault follows the request edge by one cycle; at READ_LATENCY=1 this
// is also the cycle in which a faulting load's read_valid appears.
module data_memory_unit #(
    parameter logic [31:0] ADDR_BASE    = 32'h0010_0000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] memory_addr,
    input  logic [2:0]  data_type,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        access_fault,
    output logic        fault_sticky,
    output logic [31:0] fault_addr,
    input  logic        fault_clear
);

    localparam int          DATA_W = 32;
    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam int          LAST   = READ_LATENCY - 1;
    localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        lane_mask = 4'b1111;
        case (size)
            2'b00:   lane_mask = 4'b0001 << lane;
            2'b01:   lane_mask = 4'b0011 << lane;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] lane_replicate(input logic [1:0] size,
                                                          input logic [DATA_W-1:0] wd);
        lane_replicate = wd;
        case (size)
            2'b00:   lane_replicate = {4{wd[7:0]}};
            2'b01:   lane_replicate = {2{wd[15:0]}};
            default: lane_replicate = wd;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                       input logic [1:0] lane,
                                                       input logic [1:0] size,
                                                       input logic       zext);
        logic        [7:0]  b;
        logic signed [15:0] h;
        b = word[7:0];
        case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        load_extend = '0;
        case (size)
            2'b00:   load_extend = {{24{~zext & b[7]}}, b};
            2'b01:   load_extend = {{16{~zext & h[15]}}, h};
            2'b10:   load_extend = word;
            default: load_extend = '0;
        endcase
    endfunction

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [31:0]      off;
    logic             in_range;
    logic             misaligned;
    logic             fault;
    logic             store_en;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       size;
    logic [1:0]       lane;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;

    logic [READ_LATENCY-1:0] vld_p;
    logic [READ_LATENCY-1:0] flt_p;
    logic [1:0]              lane_p [READ_LATENCY];
    logic [1:0]              size_p [READ_LATENCY];
    logic                    zext_p [READ_LATENCY];
    logic [DATA_W-1:0]       word_p [READ_LATENCY];

    // Request decode
    always_comb begin
        size       = data_type[1:0];
        lane       = memory_addr[1:0];
        off        = memory_addr - ADDR_BASE;
        in_range   = (memory_addr >= ADDR_BASE) && (off < SPAN);
        misaligned = (size == 2'b01 && lane[0]) ||
                     (size == 2'b10 && lane != 2'b00) ||
                     (size == 2'b11);
        fault      = ((read_enable || write_enable) && (!in_range || misaligned)) ||
                     (read_enable && write_enable);
        word_idx   = off[IDX_W+1:2];
        // No store on a reset edge; fault already covers simultaneous read+write.
        store_en   = write_enable && !fault && reset_n;
        wr_mask    = lane_mask(size, lane);
        wr_data    = lane_replicate(size, write_data);
    end

    // Stage p0: RAM access; later stages are plain delay registers
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (read_enable) word_p[0] <= mem[word_idx];
        for (int s = 1; s < READ_LATENCY; s++) word_p[s] <= word_p[s-1];
    end

    always_ff @(posedge clk) begin
        lane_p[0] <= lane;
        size_p[0] <= size;
        zext_p[0] <= data_type[2];
        flt_p[0]  <= fault;
        for (int s = 1; s < READ_LATENCY; s++) begin
            lane_p[s] <= lane_p[s-1];
            size_p[s] <= size_p[s-1];
            zext_p[s] <= zext_p[s-1];
            flt_p[s]  <= flt_p[s-1];
        end
    end

    // Control: valid pipe and fault capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p        <= '0;
            access_fault <= 1'b0;
            fault_sticky <= 1'b0;
            fault_addr   <= '0;
        end else begin
            vld_p[0] <= read_enable;
            for (int s = 1; s < READ_LATENCY; s++) vld_p[s] <= vld_p[s-1];
            access_fault <= fault;
            // A fresh fault beats a simultaneous clear.
            if (fault && (!fault_sticky || fault_clear)) begin
                fault_sticky <= 1'b1;
                fault_addr   <= memory_addr;
            end else if (fault_clear) begin
                fault_sticky <= 1'b0;
                fault_addr   <= '0;
            end
        end
    end

    // Output stage: lane extraction and extension
    always_comb begin
        read_valid = vld_p[LAST];
        read_data  = '0;
        if (vld_p[LAST] && !flt_p[LAST])
            read_data = load_extend(word_p[LAST], lane_p[LAST], size_p[LAST], zext_p[LAST]);
    end

endmodule
